// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state enums, mul/div classifier.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_SLTU  = 4'h6,
    ALU_SLL   = 4'h7,
    ALU_SRL   = 4'h8,
    ALU_SRA   = 4'h9,
    ALU_MUL   = 4'hA,
    ALU_MULHU = 4'hB,
    ALU_DIVU  = 4'hC,
    ALU_REMU  = 4'hD,
    ALU_ILL0  = 4'hE,
    ALU_ILL1  = 4'hF
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input aluop_e op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU engine, one bit per cycle.
// Latency: XLen cycles after start_i; done_o pulses in the last iteration cycle.
// Backpressure: none; the caller starts it only when idle and captures result_o on done_o.
// Ports: clk_i/rst_i clock and sync active-high reset; start_i loads operands (op_i, a_i, b_i);
//        done_o marks the final step; result_o is the selected half of the post-step register.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLen = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  aluop_e          op_i,
  input  logic [XLen-1:0] a_i,
  input  logic [XLen-1:0] b_i,
  output logic            done_o,
  output logic [XLen-1:0] result_o
);

  localparam int CW = $clog2(XLen) + 1;

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  // Shared 2*XLen register. Multiply: {partial product, remaining multiplier bits}.
  // Divide: {partial remainder, dividend bits being turned into quotient bits}.
  logic [2*XLen-1:0] r_prod;
  logic [XLen-1:0]   r_opb;     // multiplicand (mul) or divisor (div)
  logic              r_is_div;
  logic              r_hi_sel;  // MULHU / REMU take the upper half

  logic [XLen-1:0]   w_hi;
  logic [XLen-1:0]   w_lo;
  logic [XLen:0]     w_madd;
  logic [XLen:0]     w_dtrial;
  logic [2*XLen-1:0] w_mul_nxt;
  logic [2*XLen-1:0] w_div_nxt;
  logic [2*XLen-1:0] w_nxt;

  assign w_hi = r_prod[2*XLen-1:XLen];
  assign w_lo = r_prod[XLen-1:0];

  // Shift-add: add multiplicand when the current multiplier LSB is set, then shift right.
  assign w_madd    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_madd, w_lo[XLen-1:1]};

  // Restoring step: trial-subtract the divisor from the shifted remainder; a borrow
  // (MSB set) means restore, i.e. just shift. A zero divisor never borrows, which
  // naturally yields quotient all-ones and remainder equal to the dividend.
  assign w_dtrial  = {w_hi, w_lo[XLen-1]} - {1'b0, r_opb};
  assign w_div_nxt = w_dtrial[XLen] ? {w_hi[XLen-2:0], w_lo, 1'b0}
                                    : {w_dtrial[XLen-1:0], w_lo[XLen-2:0], 1'b1};

  assign w_nxt    = r_is_div ? w_div_nxt : w_mul_nxt;
  assign done_o   = r_busy && (r_cnt == CW'(XLen - 1));
  assign result_o = r_hi_sel ? w_nxt[2*XLen-1:XLen] : w_nxt[XLen-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_hi_sel <= 1'b0;
    end else if (start_i) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_is_div <= (op_i == ALU_DIVU) || (op_i == ALU_REMU);
      r_hi_sel <= (op_i == ALU_MULHU) || (op_i == ALU_REMU);
      if ((op_i == ALU_DIVU) || (op_i == ALU_REMU)) begin
        r_prod <= {{XLen{1'b0}}, a_i};
        r_opb  <= b_i;
      end else begin
        r_prod <= {{XLen{1'b0}}, b_i};
        r_opb  <= a_i;
      end
    end else if (r_busy) begin
      r_prod <= w_nxt;
      r_cnt  <= r_cnt + CW'(1);
      if (done_o) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I-style ALU with iterative unsigned MUL/MULHU/DIVU/REMU, one op in flight.
// Latency: 1 cycle accept-to-response for single-cycle/illegal ops, XLen+1 for mul/div.
// Backpressure: req_ready_o low while busy or holding an unconsumed response; outputs held stable.
// Ports: clk_i/rst_i sync active-high reset; req_valid_i/req_ready_o with a_i, b_i, alu_control_i;
//        rsp_valid_o/rsp_ready_i with registered result_o, zero_o, err_o.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLen     = 32,
  parameter int EnMulDiv = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLen-1:0] a_i,
  input  logic [XLen-1:0] b_i,
  input  logic [3:0]      alu_control_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLen-1:0] result_o,
  output logic            zero_o,
  output logic            err_o
);

  localparam int SW = $clog2(XLen);

  state_e          r_state;
  logic [XLen-1:0] r_result;
  logic            r_zero;
  logic            r_err;

  aluop_e          w_op;
  logic            w_is_md;
  logic            w_md_ok;
  logic            w_legal;
  logic            w_accept;
  logic            w_md_start;
  logic            w_md_done;
  logic [XLen-1:0] w_md_res;
  logic [SW-1:0]   w_shamt;
  logic [XLen-1:0] w_single;

  assign w_op     = aluop_e'(alu_control_i);
  assign w_is_md  = is_muldiv(w_op);
  assign w_md_ok  = w_is_md && (EnMulDiv != 0);
  assign w_legal  = w_md_ok || (!w_is_md && (w_op != ALU_ILL0) && (w_op != ALU_ILL1));
  assign w_shamt  = b_i[SW-1:0];

  // A response being consumed frees the slot in the same cycle, giving 1 op/clk throughput.
  assign req_ready_o = (r_state == IDLE) || ((r_state == DONE) && rsp_ready_i);
  assign rsp_valid_o = (r_state == DONE);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_md_start  = w_accept && w_md_ok;

  assign result_o = r_result;
  assign zero_o   = r_zero;
  assign err_o    = r_err;

  always_comb begin
    w_single = '0;
    case (w_op)
      ALU_ADD:  w_single = a_i + b_i;
      ALU_SUB:  w_single = a_i - b_i;
      ALU_AND:  w_single = a_i & b_i;
      ALU_OR:   w_single = a_i | b_i;
      ALU_XOR:  w_single = a_i ^ b_i;
      ALU_SLT:  w_single = {{(XLen-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: w_single = {{(XLen-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:  w_single = a_i << w_shamt;
      ALU_SRL:  w_single = a_i >> w_shamt;
      ALU_SRA:  w_single = $unsigned($signed(a_i) >>> w_shamt);
      default:  w_single = '0;
    endcase
  end

  alu_muldiv_iter #(
    .XLen(XLen)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (w_md_start),
    .op_i     (w_op),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (w_md_done),
    .result_o (w_md_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_md_ok) begin
              r_state <= ITER;
            end else begin
              r_state  <= DONE;
              r_result <= w_legal ? w_single : '0;
              r_zero   <= w_legal ? (w_single == '0) : 1'b1;
              r_err    <= !w_legal;
            end
          end else if ((r_state == DONE) && rsp_ready_i) begin
            r_state <= IDLE;
          end
        end
        ITER: begin
          if (w_md_done) begin
            r_state  <= DONE;
            r_result <= w_md_res;
            r_zero   <= (w_md_res == '0);
            r_err    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: scoreboard queue filled at request accept, drained by a monitor.
// Latency: n/a.
// Backpressure: exercised with directed stalls and random rsp_ready_i.
module tb_alu_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  alu_control_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        err_o;

  logic        n_req_valid;
  logic        n_req_ready;
  logic [31:0] n_a;
  logic [31:0] n_b;
  logic [3:0]  n_ctl;
  logic        n_rsp_valid;
  logic        n_rsp_ready;
  logic [31:0] n_result;
  logic        n_zero;
  logic        n_err;

  always #5 clk_i = ~clk_i;

  alu_mc #(.XLen(32), .EnMulDiv(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .a_i(a_i), .b_i(b_i), .alu_control_i(alu_control_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .result_o(result_o), .zero_o(zero_o), .err_o(err_o)
  );

  alu_mc #(.XLen(32), .EnMulDiv(0)) u_nomd (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(n_req_valid), .req_ready_o(n_req_ready),
    .a_i(n_a), .b_i(n_b), .alu_control_i(n_ctl),
    .rsp_valid_o(n_rsp_valid), .rsp_ready_i(n_rsp_ready),
    .result_o(n_result), .zero_o(n_zero), .err_o(n_err)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  int   first_cyc = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every response transfer against the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_i) begin
      seen = 1'b0;
    end else if (rsp_valid_o) begin
      if (!seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (rsp_ready_i) begin
        seen = 1'b0;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got result %h with no request outstanding", result_o);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp", {30'b0, result_o, zero_o, err_o}, {30'b0, mon_e.res, mon_e.zero, mon_e.err});
          if (mon_e.lat >= 0) chk("latency", 64'(first_cyc - mon_e.acc), 64'(mon_e.lat));
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (rand_rdy) begin
      #1;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (rsp_valid_o && !rsp_ready_i) |=>
      (rsp_valid_o && $stable(result_o) && $stable(zero_o) && $stable(err_o)))
    else begin
      errors++;
      $display("FAIL sva_stable: response changed under backpressure, result now %h", result_o);
    end

  a_drop: assert property (@(posedge clk_i)
      $fell(rsp_valid_o) |-> ($past(rsp_ready_i) || $past(rst_i)))
    else begin
      errors++;
      $display("FAIL sva_drop: rsp_valid_o fell without transfer or reset");
    end

  // Called aligned to posedge+1; returns aligned to posedge+1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ee, input int lat);
    int   n;
    exp_t e;
    req_valid_i   = 1'b1;
    alu_control_i = op;
    a_i           = a;
    b_i           = b;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 500) begin
      n++;
      @(negedge clk_i);
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: req_ready_o=%0b after %0d cycles, expected 1", req_ready_o, n);
    end else begin
      e.res  = er;
      e.zero = (er == 32'h0);
      e.err  = ee;
      e.lat  = lat;
      e.acc  = cyc;
      sbq.push_back(e);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    r = 32'h0;
    e = 1'b0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = {31'b0, ($signed(a) < $signed(b))};
      4'h6: r = {31'b0, (a < b)};
      4'h7: r = a << b[4:0];
      4'h8: r = a >> b[4:0];
      4'h9: r = $unsigned($signed(a) >>> b[4:0]);
      4'hA: r = p[31:0];
      4'hB: r = p[63:32];
      4'hC: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hD: r = (b == 0) ? a : a % b;
      default: e = 1'b1;
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rr;
    logic        re;
    int          nv;
    rst_i = 1'b1;
    req_valid_i = 1'b0; a_i = '0; b_i = '0; alu_control_i = '0; rsp_ready_i = 1'b1;
    n_req_valid = 1'b0; n_a = '0; n_b = '0; n_ctl = '0; n_rsp_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_outputs", {30'b0, result_o, zero_o, err_o}, 64'd0);
    chk("reset_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // Directed single-cycle ops
    send(4'h0, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
    send(4'h5, 32'h8000_0000, 32'h1,        32'h1,         1'b0, 1);
    send(4'h6, 32'h8000_0000, 32'h1,        32'h0,         1'b0, 1);
    send(4'h9, 32'h8000_0000, 32'h21,       32'hC000_0000, 1'b0, 1);
    send(4'h1, 32'h0,         32'h1,        32'hFFFF_FFFF, 1'b0, 1);
    send(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
    send(4'h3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1);
    send(4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
    send(4'h7, 32'h1,         32'd31,       32'h8000_0000, 1'b0, 1);
    send(4'h8, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 1);
    // Iterative ops
    send(4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0, 33);
    send(4'hB, 32'h0001_0000, 32'h0001_0000, 32'h1,         1'b0, 33);
    send(4'hA, 32'd7,         32'd9,         32'd63,        1'b0, 33);
    send(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    send(4'hC, 32'd100,       32'd7,         32'd14,        1'b0, 33);
    send(4'hD, 32'd100,       32'd7,         32'd2,         1'b0, 33);
    send(4'hC, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 33);
    send(4'hD, 32'd5,         32'd0,         32'd5,         1'b0, 33);
    // Illegal opcodes
    send(4'hF, 32'd1,         32'd2,         32'h0,         1'b1, 1);
    send(4'hE, 32'd3,         32'd4,         32'h0,         1'b1, 1);
    drain();

    // Backpressure: hold the response, then four back-to-back ADDs
    rsp_ready_i = 1'b0;
    send(4'h0, 32'd7, 32'd8, 32'd15, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
      chk("bp_result", 64'(result_o), 64'd15);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
    end
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    send(4'h0, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    send(4'h0, 32'd2, 32'd2, 32'd4, 1'b0, 1);
    send(4'h0, 32'd3, 32'd3, 32'd6, 1'b0, 1);
    send(4'h0, 32'd4, 32'd4, 32'd8, 1'b0, 1);
    drain();

    // Reset in the middle of a DIVU: no response must come out
    send(4'hC, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    repeat (9) @(posedge clk_i);
    #1 rst_i = 1'b1;
    sbq.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready_o), 64'd1);
    nv = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (rsp_valid_o) nv++;
    end
    chk("rst_mid_no_rsp", 64'(nv), 64'd0);
    @(posedge clk_i);
    #1;
    send(4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    drain();

    // Instance without mul/div: MUL is illegal
    n_ctl = 4'hA; n_a = 32'd3; n_b = 32'd4; n_req_valid = 1'b1;
    @(negedge clk_i);
    chk("nomd_req_ready", 64'(n_req_ready), 64'd1);
    @(posedge clk_i);
    #1 n_req_valid = 1'b0;
    @(negedge clk_i);
    chk("nomd_rsp_valid", 64'(n_rsp_valid), 64'd1);
    chk("nomd_rsp", {30'b0, n_result, n_zero, n_err}, {30'b0, 32'h0, 1'b1, 1'b1});
    @(posedge clk_i);
    #1;

    // Random ops against the reference model with random stalls
    rand_rdy = 1'b1;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < ((op < 14) ? 256 : 16); k++) begin
        ra = $urandom;
        rb = $urandom;
        if (k % 4 == 1) rb = $urandom_range(1, 1000);
        if (k % 16 == 0) rb = 32'h0;
        model(4'(op), ra, rb, rr, re);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_i);
          #1;
        end
        send(4'(op), ra, rb, rr, re, (op >= 10 && op <= 13) ? 33 : 1);
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk_i);
    #2 rsp_ready_i = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
